// File: rtl/risc_pkg.sv
// Shared RISC_1 core definitions: datapath width, PC increment, fetch FSM states and word helpers.
package risc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PC_INC = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic word_t align_word(input word_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry output slot between fetch and decode: load wins over drain, flush wins over both.
module fetch_out_buf
  import risc_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc + XLEN'(PC_INC);
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// RISC_1 instruction-fetch stage: PC, imem valid/ready requests, redirect handling, one-entry output.
// Defining FETCH_PERF_CNT_EN adds the fetch_count port counting decode handshakes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = risc_pkg::RESET_PC_DEFAULT,
  parameter int unsigned XLEN     = risc_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  import risc_pkg::*;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;

  logic            w_slot_free;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_drain;
  logic            w_load;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redir_pc;

  // A request may only go out when its response is guaranteed a free slot.
  assign w_drain     = out_valid && out_ready;
  assign w_slot_free = !out_valid || out_ready;
  assign w_req_valid = (r_state == REQ) && w_slot_free;
  assign w_accept    = w_req_valid && imem_req_ready;
  assign w_load      = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pc_plus4  = r_pc + XLEN'(PC_INC);
  assign w_redir_pc  = align_word(redirect_pc);

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        r_pc <= w_redir_pc;
      end else if (w_load) begin
        r_pc <= w_pc_plus4;
      end

      // Redirect with a response still owed sends us to DRAIN to discard it.
      case (r_state)
        IDLE:    r_state <= REQ;
        REQ:     if (w_accept) r_state <= redirect_valid ? DRAIN : WAIT;
        WAIT: begin
          if (imem_rsp_valid)      r_state <= REQ;
          else if (redirect_valid) r_state <= DRAIN;
        end
        DRAIN:   if (imem_rsp_valid) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_out_buf u_out_buf (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_drain    (w_drain),
    .i_flush    (redirect_valid),
    .i_instr    (imem_rsp_data),
    .i_pc       (r_pc),
    .o_valid    (out_valid),
    .o_instr    (out_instr),
    .o_pc       (out_pc),
    .o_pc_plus4 (out_pc_plus4)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_drain) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory/decode/redirect traffic against a stream model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, rsp_valid, out_valid, out_ready, redir_valid;
  logic [31:0] addr, rsp_data, out_instr, out_pc, out_pc_plus4, redir_pc;

  logic        hi_req_valid, hi_rsp_valid, hi_out_valid;
  logic [31:0] hi_addr, hi_rsp_data, hi_out_instr, hi_out_pc, hi_out_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, hi_fetch_count;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .redirect_valid(redir_valid), .redirect_pc(redir_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  // Second instance starting at the top of the address space, always ready, echo memory.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst(rst),
    .imem_req_valid(hi_req_valid), .imem_req_ready(1'b1), .imem_addr(hi_addr),
    .imem_rsp_valid(hi_rsp_valid), .imem_rsp_data(hi_rsp_data),
    .out_valid(hi_out_valid), .out_ready(1'b1), .out_instr(hi_out_instr),
    .out_pc(hi_out_pc), .out_pc_plus4(hi_out_pc_plus4),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(hi_fetch_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] hs_log[$];
  int          hs_cyc[$];
  logic [31:0] hi_log[$];
  logic [31:0] hi_p4_log[$];

  logic [31:0] exp_pc, last_acc, hi_pend_addr, f_redir_pc;
  int          cyc, n_acc, n_hs, cnt_model;
  bit          hi_pend, f_redir;
  bit          p_ov, p_ordy, p_rv, p_rr, p_redir;
  logic [31:0] p_pc, p_instr, p_addr;

  int k_rdy, k_lat_lo, k_lat_hi, k_ordy, k_redir;
  bit k_echo;

  // Memory content: the address itself (echo) or a scrambled word derived from it.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit echo);
    return echo ? a : ({a[15:0], a[31:16]} ^ 32'h1357_9BDF);
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 | 32'($urandom_range(15));
      2:       return 32'($urandom_range(255));
      default: return $urandom;
    endcase
  endfunction

  // One clock of traffic: drive at negedge, sample and update the model just after.
  task automatic step();
    int lat;
    @(negedge clk);
    cyc++;
    req_ready = ($urandom_range(99) < k_rdy);
    out_ready = ($urandom_range(99) < k_ordy);
    if (f_redir) begin
      redir_valid = 1'b1;
      redir_pc    = f_redir_pc;
      f_redir     = 1'b0;
    end else begin
      redir_valid = ($urandom_range(99) < k_redir);
      redir_pc    = pick_target();
    end
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pq[0].a, k_echo);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    hi_rsp_valid = hi_pend;
    hi_rsp_data  = hi_pend_addr;
    #1;
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'(cnt_model));
`endif
    if (p_ov && !p_ordy && !p_redir) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pc", out_pc, p_pc);
      check("hold_instr", out_instr, p_instr);
    end
    if (p_rv && !p_rr && !p_redir) begin
      check("req_hold_valid", 32'(req_valid), 32'd1);
      check("req_hold_addr", addr, p_addr);
    end
    if (out_valid && out_ready) begin
      check("hs_pc", out_pc, exp_pc);
      check("hs_instr", out_instr, mem_word(exp_pc, k_echo));
      check("hs_pc4", out_pc_plus4, exp_pc + 32'd4);
      hs_log.push_back(out_pc);
      hs_cyc.push_back(cyc);
      n_hs++;
      cnt_model++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redir_valid) exp_pc = {redir_pc[31:2], 2'b00};
    if (rsp_valid) pq.delete(0);
    if (req_valid && req_ready) begin
      check("one_outstanding", 32'(pq.size()), 32'd0);
      check("addr_align", 32'(addr[1:0]), 32'd0);
      lat = int'($urandom_range(k_lat_hi, k_lat_lo));
      pq.push_back('{a: addr, due: cyc + lat});
      n_acc++;
      last_acc = addr;
    end
    if (hi_out_valid) begin
      hi_log.push_back(hi_out_pc);
      hi_p4_log.push_back(hi_out_pc_plus4);
      check("hi_instr", hi_out_instr, hi_out_pc);
    end
    hi_pend      = hi_req_valid;
    hi_pend_addr = hi_addr;
    p_ov = out_valid; p_ordy = out_ready; p_redir = redir_valid;
    p_rv = req_valid; p_rr = req_ready;
    p_pc = out_pc; p_instr = out_instr; p_addr = addr;
  endtask

  task automatic apply_reset(input bit async_now);
    if (async_now) #2;
    else @(negedge clk);
    rst = 1'b1;
    req_ready = 1'b0; out_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    rsp_valid = 1'b1; rsp_data = $urandom;
    hi_rsp_valid = 1'b0; hi_rsp_data = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc4", out_pc_plus4, 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_hi_addr", hi_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pq.delete(); hs_log.delete(); hs_cyc.delete(); hi_log.delete(); hi_p4_log.delete();
    exp_pc = 32'd0; n_acc = 0; n_hs = 0; cnt_model = 0; hi_pend = 1'b0;
    p_ov = 0; p_ordy = 0; p_rv = 0; p_rr = 0; p_redir = 0;
    @(posedge clk);
    #1;
    check("idle_drops_rsp", 32'(out_valid), 32'd0);
    check("first_req_valid", 32'(req_valid), 32'd1);
    check("first_req_addr", addr, 32'd0);
    rsp_valid = 1'b0;
  endtask

  task automatic wait_acc(input string tag);
    int base;
    base = n_acc;
    for (int i = 0; i < 50 && n_acc == base; i++) step();
    if (n_acc == base) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_hs(input string tag);
    int base;
    base = n_hs;
    for (int i = 0; i < 50 && n_hs == base; i++) step();
    if (n_hs == base) check(tag, 32'd0, 32'd1);
  endtask

  task automatic set_knobs(input int rdy, input int lo, input int hi, input int ordy,
                           input int rd, input bit echo);
    k_rdy = rdy; k_lat_lo = lo; k_lat_hi = hi; k_ordy = ordy; k_redir = rd; k_echo = echo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; f_redir = 0; f_redir_pc = '0; last_acc = '0;
    req_ready = 0; out_ready = 0; redir_valid = 0; redir_pc = '0; rsp_valid = 0; rsp_data = '0;
    hi_rsp_valid = 0; hi_rsp_data = '0;

    // Free run, echo memory: 0,4,8,12 at one per two cycles; high instance wraps.
    set_knobs(100, 1, 1, 100, 0, 1'b1);
    apply_reset(1'b0);
    for (int i = 0; i < 40 && n_hs < 4; i++) step();
    check("t1_count", 32'(n_hs >= 4), 32'd1);
    for (int i = 0; i < 4; i++) check("t1_seq_pc", hs_log[i], 32'(4 * i));
    check("t1_throughput", 32'(hs_cyc[3] - hs_cyc[2]), 32'd2);
    check("hi_first_pc", hi_log[0], 32'hFFFF_FFFC);
    check("hi_first_pc4", hi_p4_log[0], 32'd0);
    check("hi_second_pc", hi_log[1], 32'd0);

    // Decode stalls: slot holds pc 0 and no further request until release.
    set_knobs(100, 1, 1, 0, 0, 1'b1);
    apply_reset(1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    repeat (5) begin
      step();
      check("t2_stall_valid", 32'(out_valid), 32'd1);
      check("t2_stall_pc", out_pc, 32'd0);
      check("t2_no_req", 32'(req_valid), 32'd0);
    end
    k_ordy = 100;
    wait_acc("t2_acc_timeout");
    check("t2_next_addr", last_acc, 32'd4);

    // Redirect while waiting: the in-flight word at 4 is drained away.
    set_knobs(100, 2, 2, 100, 0, 1'b1);
    apply_reset(1'b0);
    for (int i = 0; i < 30 && !(n_acc == 2 && last_acc == 32'd4); i++) step();
    f_redir = 1'b1; f_redir_pc = 32'h0000_0103;
    step();
    @(posedge clk);
    #1;
    check("t3_flush_valid", 32'(out_valid), 32'd0);
    check("t3_drain_no_req", 32'(req_valid), 32'd0);
    wait_acc("t3_acc_timeout");
    check("t3_next_addr", last_acc, 32'h0000_0100);
    wait_hs("t3_hs_timeout");
    check("t3_next_pc", hs_log[$], 32'h0000_0100);

    // Redirect coincides with the response: it is dropped, fetch moves to target.
    set_knobs(100, 1, 1, 100, 0, 1'b1);
    apply_reset(1'b0);
    for (int i = 0; i < 30 && n_acc < 2; i++) step();
    f_redir = 1'b1; f_redir_pc = 32'h0000_0200;
    step();
    @(posedge clk);
    #1;
    check("t4_no_present", 32'(out_valid), 32'd0);
    wait_acc("t4_acc_timeout");
    check("t4_next_addr", last_acc, 32'h0000_0200);
    wait_hs("t4_hs_timeout");
    check("t4_next_pc", hs_log[$], 32'h0000_0200);

    // Reset asserted in WAIT with a nonzero slot history, late response ignored.
    set_knobs(100, 3, 3, 0, 0, 1'b1);
    for (int i = 0; i < 30 && !out_valid; i++) step();
    k_ordy = 100;
    wait_acc("t6_acc_timeout");
    step();
    apply_reset(1'b1);
    wait_acc("t6_acc2_timeout");
    check("t6_first_addr", last_acc, 32'd0);
    wait_hs("t6_hs_timeout");
    check("t6_first_pc", hs_log[0], 32'd0);

    // Randomized traffic against the program-order stream model.
    set_knobs(60, 1, 3, 70, 6, 1'b0);
    apply_reset(1'b0);
    repeat (3000) step();
    check("rand_liveness", 32'(n_hs > 150), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
